// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit core.
// Optional zero-bubble jump/call redirection in fetch: define FETCH_EARLY_JUMP_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  JMP_OP    = 4'b0001,
  parameter logic [3:0]  CALL_OP   = 4'b0010
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus1,
  output logic        id_early_jump
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

`ifdef FETCH_EARLY_JUMP_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] idpc_q, idpc_d;
  logic [15:0] idpc1_q, idpc1_d;
  logic        early_q, early_d;

  logic [15:0] pc_plus1;
  logic        is_jump_op;
  logic        take_jump;

  assign pc_plus1   = pc_q + 16'd1;
  assign is_jump_op = (imem_data[15:12] == JMP_OP) || (imem_data[15:12] == CALL_OP);
  // With the feature off this folds to zero and the opcode compare is pruned.
  assign take_jump  = EARLY_EN && is_jump_op;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    idpc1_d = idpc1_q;
    early_d = early_q;
    case (state_q)
      BOOT: begin
        // imem settling cycle: bubble out, PC held, redirect ignored
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        early_d = 1'b0;
        state_d = RUN;
      end
      RUN, STALL: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          early_d = 1'b0;
          state_d = RUN;
        end else if (stall) begin
          state_d = STALL;
        end else begin
          valid_d = 1'b1;
          instr_d = imem_data;
          idpc_d  = pc_q;
          idpc1_d = pc_plus1;
          early_d = take_jump;
          pc_d    = take_jump ? {pc_q[15:9], imem_data[8:0]} : pc_plus1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      idpc_q  <= 16'h0000;
      idpc1_q <= 16'h0000;
      early_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      idpc1_q <= idpc1_d;
      early_q <= early_d;
    end
  end

  assign imem_addr     = pc_q;
  assign id_valid      = valid_q;
  assign id_instr      = instr_q;
  assign id_pc         = idpc_q;
  assign id_pc_plus1   = idpc1_q;
  assign id_early_jump = early_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus async-reset and boot sequences.
// Expectations follow FETCH_EARLY_JUMP_EN when the bench is built with it.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus1;
  logic        id_early_jump;

  int n_cmp;
  int n_bad;

  fetch_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus1  (id_pc_plus1),
    .id_early_jump(id_early_jump)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory image: opcode 0xC everywhere except one JMP word at 0x1203.
  assign imem_data = (imem_addr == 16'h1203) ? 16'h10A5 : {4'hC, imem_addr[11:0]};

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc1;
    logic [15:0] addr;
    logic        early;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic s, logic r, logic [15:0] rpc, logic v, logic [15:0] ins,
                              logic [15:0] pc, logic [15:0] pc1, logic [15:0] addr, logic e);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc; t.valid = v; t.instr = ins;
    t.pc = pc; t.pc1 = pc1; t.addr = addr; t.early = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [15:0] ins,
                           input logic [15:0] pc, input logic [15:0] pc1,
                           input logic [15:0] addr, input logic e);
    check({tag, ".id_valid"},      {15'd0, id_valid},      {15'd0, v});
    check({tag, ".id_instr"},      id_instr,               ins);
    check({tag, ".id_pc"},         id_pc,                  pc);
    check({tag, ".id_pc_plus1"},   id_pc_plus1,            pc1);
    check({tag, ".imem_addr"},     imem_addr,              addr);
    check({tag, ".id_early_jump"}, {15'd0, id_early_jump}, {15'd0, e});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;

    //          st rd rpc       v  instr     pc        pc1       addr      e
    vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0)); // boot bubble
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC000, 16'h0000, 16'h0001, 16'h0001, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC001, 16'h0001, 16'h0002, 16'h0002, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC002, 16'h0002, 16'h0003, 16'h0003, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC003, 16'h0003, 16'h0004, 16'h0004, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC004, 16'h0004, 16'h0005, 16'h0005, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC005, 16'h0005, 16'h0006, 16'h0006, 0));
    vq.push_back(mk(1, 0, 16'h0000, 1, 16'hC005, 16'h0005, 16'h0006, 16'h0006, 0)); // stall x3
    vq.push_back(mk(1, 0, 16'h0000, 1, 16'hC005, 16'h0005, 16'h0006, 16'h0006, 0));
    vq.push_back(mk(1, 0, 16'h0000, 1, 16'hC005, 16'h0005, 16'h0006, 16'h0006, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC006, 16'h0006, 16'h0007, 16'h0007, 0)); // release
    vq.push_back(mk(1, 1, 16'h0040, 0, 16'h0000, 16'h0006, 16'h0007, 16'h0040, 0)); // redirect beats stall
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC040, 16'h0040, 16'h0041, 16'h0041, 0));
    vq.push_back(mk(0, 1, 16'hFFFE, 0, 16'h0000, 16'h0040, 16'h0041, 16'hFFFE, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hCFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hCFFF, 16'hFFFF, 16'h0000, 16'h0000, 0)); // wrap
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC000, 16'h0000, 16'h0001, 16'h0001, 0));
    vq.push_back(mk(0, 1, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 0)); // redirect to own PC
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC001, 16'h0001, 16'h0002, 16'h0002, 0));
    vq.push_back(mk(0, 1, 16'h1203, 0, 16'h0000, 16'h0001, 16'h0002, 16'h1203, 0));
    vq.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0001, 16'h0002, 16'h1203, 0)); // stall on JMP word
`ifdef FETCH_EARLY_JUMP_EN
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'h10A5, 16'h1203, 16'h1204, 16'h12A5, 1));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC2A5, 16'h12A5, 16'h12A6, 16'h12A6, 0));
`else
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'h10A5, 16'h1203, 16'h1204, 16'h1204, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 16'hC204, 16'h1204, 16'h1205, 16'h1205, 0));
`endif

    step();
    step();
    check_all("reset", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      stall       = vq[i].stall;
      redirect    = vq[i].redirect;
      redirect_pc = vq[i].rpc;
      step();
      check_all($sformatf("vec%0d", i), vq[i].valid, vq[i].instr, vq[i].pc,
                vq[i].pc1, vq[i].addr, vq[i].early);
    end

    // Async reset while stalled: outputs clear without a clock edge.
    stall = 1'b1;
    redirect = 1'b0;
    step();
    #3;
    RST = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #2;
    RST = 1'b0;
    stall = 1'b0;

    // Boot cycle must ignore a redirect request.
    redirect = 1'b1;
    redirect_pc = 16'h0300;
    step();
    check_all("boot_redir", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    redirect = 1'b0;
    step();
    check_all("post_boot", 1'b1, 16'hC000, 16'h0000, 16'h0001, 16'h0001, 1'b0);

    // Redirect issued from the STALL state.
    stall = 1'b1;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0777;
    step();
    check_all("stall_redir", 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0777, 1'b0);
    stall = 1'b0;
    redirect = 1'b0;
    step();
    check_all("stall_redir2", 1'b1, 16'hC777, 16'h0777, 16'h0778, 16'h0778, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
